// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - shared ALU opcodes and Z capture FSM encoding
package mini_src_pkg;

  // ALU opcodes shared with the ALU and control unit
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;
  localparam logic [4:0] OP_INC  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WB      = 2'd3
  } zc_state_t;

  // MUL/DIV produce a 64-bit result that must also be written back to HI/LO
  function automatic logic is_hilo_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_capture_stage_if.sv
// rtl/z_capture_stage_if.sv - control/ALU/bus signals of the Z capture stage
interface z_capture_stage_if;
  logic        start;
  logic [4:0]  alu_op;
  logic [63:0] alu_result;
  logic        zlo_rd;
  logic        zhi_rd;
  logic        busy;
  logic        done;
  logic [31:0] bus_out;
  logic        bus_drive;
  logic        flag_zero;
  logic        flag_neg;
  logic        hilo_we;
  logic [31:0] hilo_hi;
  logic [31:0] hilo_lo;
  logic        overrun;
  logic        rd_conflict;

  modport master (
    output start, alu_op, alu_result, zlo_rd, zhi_rd,
    input  busy, done, bus_out, bus_drive, flag_zero, flag_neg,
           hilo_we, hilo_hi, hilo_lo, overrun, rd_conflict
  );

  modport slave (
    input  start, alu_op, alu_result, zlo_rd, zhi_rd,
    output busy, done, bus_out, bus_drive, flag_zero, flag_neg,
           hilo_we, hilo_hi, hilo_lo, overrun, rd_conflict
  );
endinterface

// File: rtl/z_flag_gen.sv
// rtl/z_flag_gen.sv - zero/negative flag derivation from opcode and 64-bit result
module z_flag_gen
  import mini_src_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [63:0] res,
  output logic        zero,
  output logic        neg
);

  // MUL flags cover the full 64-bit product; everything else looks at the low word
  always_comb begin
    zero = (res[31:0] == 32'd0);
    neg  = res[31];
    case (op)
      OP_MUL: begin
        zero = (res == 64'd0);
        neg  = res[63];
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_INC, OP_DIV: begin
        zero = (res[31:0] == 32'd0);
        neg  = res[31];
      end
      default: begin
        zero = (res[31:0] == 32'd0);
        neg  = res[31];
      end
    endcase
  end

endmodule

// File: rtl/z_capture_stage.sv
// rtl/z_capture_stage.sv - settle-delayed capture of ALU result into ZHI/ZLO
module z_capture_stage
  import mini_src_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic              clock,
  input  logic              clear,
  z_capture_stage_if.slave  zif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  zc_state_t        state;
  zc_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_q;
  logic [31:0]      zhi;
  logic [31:0]      zlo;
  logic             flag_zero_q;
  logic             flag_neg_q;
  logic             done_q;
  logic             hilo_we_q;
  logic             overrun_q;
  logic             rd_conflict_q;
  logic             fz;
  logic             fn;
  logic             busy;

  assign busy = (state != ST_IDLE);

  z_flag_gen u_flag_gen (
    .op   (op_q),
    .res  (zif.alu_result),
    .zero (fz),
    .neg  (fn)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // sequencing: wait out the settle delay, capture, optional HI/LO write-back
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (zif.start) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (cnt == '0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = is_hilo_op(op_q) ? ST_WB : ST_IDLE;
      ST_WB:      state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // counter, opcode latch, Z registers, flags, pulses and sticky error bits
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt           <= '0;
      op_q          <= '0;
      zhi           <= '0;
      zlo           <= '0;
      flag_zero_q   <= 1'b0;
      flag_neg_q    <= 1'b0;
      done_q        <= 1'b0;
      hilo_we_q     <= 1'b0;
      overrun_q     <= 1'b0;
      rd_conflict_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && zif.start) begin
        op_q <= zif.alu_op;
        cnt  <= CNT_INIT;
      end else if (state == ST_SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ST_CAPTURE) begin
        {zhi, zlo}  <= zif.alu_result;
        flag_zero_q <= fz;
        flag_neg_q  <= fn;
      end
      done_q    <= (state == ST_CAPTURE);
      hilo_we_q <= (state == ST_WB);
      if (busy && zif.start)        overrun_q     <= 1'b1;
      if (zif.zlo_rd && zif.zhi_rd) rd_conflict_q <= 1'b1;
    end
  end

  // bus source select; ZLO has priority when both halves are requested
  always_comb begin
    zif.bus_out   = 32'd0;
    zif.bus_drive = zif.zlo_rd | zif.zhi_rd;
    if (zif.zlo_rd)      zif.bus_out = zlo;
    else if (zif.zhi_rd) zif.bus_out = zhi;
  end

  assign zif.busy        = busy;
  assign zif.done        = done_q;
  assign zif.flag_zero   = flag_zero_q;
  assign zif.flag_neg    = flag_neg_q;
  assign zif.hilo_we     = hilo_we_q;
  assign zif.hilo_hi     = zhi;
  assign zif.hilo_lo     = zlo;
  assign zif.overrun     = overrun_q;
  assign zif.rd_conflict = rd_conflict_q;

endmodule
